// File: rtl/trdb_d5m_pixel_source_if.sv
// Video bus of the D5M-style pixel source: control inputs plus the timed pixel stream.
// master = pixel source, slave = pixel consumer.
interface trdb_d5m_pixel_source_if;
    logic        ul1Enable;
    logic        ul1SnapshotMode;
    logic        ul1SnapshotTrigger;
    logic [1:0]  ul2Pattern;
    logic [11:0] ul12PixelData;
    logic        ul1LineValid;
    logic        ul1FrameValid;
    logic        ul1SnapshotStrobe;
    logic        ul1FrameDone;
    logic [15:0] u16FrameCount;

    modport master (
        input  ul1Enable, ul1SnapshotMode, ul1SnapshotTrigger, ul2Pattern,
        output ul12PixelData, ul1LineValid, ul1FrameValid, ul1SnapshotStrobe,
        ul1FrameDone, u16FrameCount
    );

    modport slave (
        output ul1Enable, ul1SnapshotMode, ul1SnapshotTrigger, ul2Pattern,
        input  ul12PixelData, ul1LineValid, ul1FrameValid, ul1SnapshotStrobe,
        ul1FrameDone, u16FrameCount
    );
endinterface

// File: rtl/trdb_d5m_pixel_source.sv
// Test-pattern camera source emitting D5M FrameValid/LineValid timing; snapshot mode under TRDB_D5M_PIXEL_SOURCE_SNAPSHOT_EN.
// Latency: FrameValid rises one clock after the start condition is sampled; all outputs registered.
// Backpressure: none, free-running one pixel per clock; the consumer must keep up.
module trdb_d5m_pixel_source #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int HBLANK      = 16,
    parameter int VBLANK      = 8
) (
    input  logic                            ul1Clock,
    input  logic                            ul1Reset,
    trdb_d5m_pixel_source_if.master         vid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRAME_START,
        S_ACTIVE,
        S_HBLANK,
        S_FRAME_END
    } state_t;

    localparam logic [15:0] LAST_COL = 16'(ACTIVE_COLS - 1);
    localparam logic [15:0] LAST_ROW = 16'(ACTIVE_ROWS - 1);
    localparam logic [15:0] LAST_HB  = 16'(HBLANK - 1);
    localparam logic [15:0] LAST_VB  = 16'(VBLANK - 1);

    state_t      state;
    logic [15:0] timer;
    logic [15:0] col;
    logic [15:0] row;
    logic [1:0]  patLatch;
    logic [11:0] pixelData;
    logic        lineValid;
    logic        frameValid;
    logic        snapStrobe;
    logic        frameDone;
    logic [15:0] frameCount;
    logic        snapMode;
    logic        snapTrig;

`ifdef TRDB_D5M_PIXEL_SOURCE_SNAPSHOT_EN
    assign snapMode = vid.ul1SnapshotMode;
    assign snapTrig = vid.ul1SnapshotTrigger;
`else
    logic unusedSnapIn;
    assign unusedSnapIn = vid.ul1SnapshotMode ^ vid.ul1SnapshotTrigger;
    assign snapMode     = 1'b0;
    assign snapTrig     = 1'b0;
`endif

    function automatic logic [11:0] pixelOf(input logic [1:0] pat, input logic [15:0] c,
                                            input logic [15:0] r, input logic [15:0] fc);
        logic [11:0] v;
        case (pat)
            2'b00:   v = c[11:0];
            2'b01:   v = r[11:0];
            2'b10:   v = c[11:0] + r[11:0];
            default: v = fc[11:0];
        endcase
        return v;
    endfunction

    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            col        <= '0;
            row        <= '0;
            patLatch   <= '0;
            pixelData  <= '0;
            lineValid  <= 1'b0;
            frameValid <= 1'b0;
            snapStrobe <= 1'b0;
            frameDone  <= 1'b0;
            frameCount <= '0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vid.ul1Enable && (!snapMode || snapTrig)) begin
                        state      <= S_FRAME_START;
                        timer      <= '0;
                        patLatch   <= vid.ul2Pattern;
                        frameValid <= 1'b1;
                        snapStrobe <= snapMode;
                    end
                end
                S_FRAME_START: begin
                    if (timer == LAST_HB) begin
                        state      <= S_ACTIVE;
                        col        <= '0;
                        row        <= '0;
                        lineValid  <= 1'b1;
                        pixelData  <= pixelOf(patLatch, 16'd0, 16'd0, frameCount);
                        snapStrobe <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_ACTIVE: begin
                    if (col == LAST_COL) begin
                        lineValid <= 1'b0;
                        pixelData <= '0;
                        timer     <= '0;
                        if (row == LAST_ROW) begin
                            // Count is bumped together with the done pulse so both are visible in the same cycle.
                            state      <= S_FRAME_END;
                            frameValid <= 1'b0;
                            frameDone  <= 1'b1;
                            frameCount <= frameCount + 16'd1;
                        end else begin
                            state <= S_HBLANK;
                        end
                    end else begin
                        col       <= col + 16'd1;
                        pixelData <= pixelOf(patLatch, col + 16'd1, row, frameCount);
                    end
                end
                S_HBLANK: begin
                    if (timer == LAST_HB) begin
                        state     <= S_ACTIVE;
                        col       <= '0;
                        row       <= row + 16'd1;
                        lineValid <= 1'b1;
                        pixelData <= pixelOf(patLatch, 16'd0, row + 16'd1, frameCount);
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_FRAME_END: begin
                    if (timer == LAST_VB) begin
                        timer <= '0;
                        // Mode and enable are only looked at here, so a frame in flight is never cut short.
                        if (vid.ul1Enable && !snapMode) begin
                            state      <= S_FRAME_START;
                            patLatch   <= vid.ul2Pattern;
                            frameValid <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    frameValid <= 1'b0;
                    lineValid  <= 1'b0;
                    pixelData  <= '0;
                    snapStrobe <= 1'b0;
                end
            endcase
        end
    end

    assign vid.ul12PixelData     = pixelData;
    assign vid.ul1LineValid      = lineValid;
    assign vid.ul1FrameValid     = frameValid;
    assign vid.ul1SnapshotStrobe = snapStrobe;
    assign vid.ul1FrameDone      = frameDone;
    assign vid.u16FrameCount     = frameCount;

endmodule

// File: tb/tb_trdb_d5m_pixel_source.sv
// Bench for trdb_d5m_pixel_source with a 4x3 frame, HBLANK=2, VBLANK=5.
// A frame-position model is compared every cycle; directed frames pin literal results.
module tb_trdb_d5m_pixel_source;
    localparam int C = 4;
    localparam int R = 3;
    localparam int H = 2;
    localparam int V = 5;
    localparam int L = H + R * C + (R - 1) * H;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trdb_d5m_pixel_source_if vif();

    trdb_d5m_pixel_source #(
        .ACTIVE_COLS(C), .ACTIVE_ROWS(R), .HBLANK(H), .VBLANK(V)
    ) dut (
        .ul1Clock(clk),
        .ul1Reset(rst),
        .vid(vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame position p counts clocks from the first FrameValid cycle.
    logic        mRun   = 1'b0;
    int          p      = 0;
    logic [1:0]  mPat   = 2'b00;
    logic        mSnap  = 1'b0;
    logic [15:0] mCount = 16'd0;
    logic        mLoad  = 1'b0;

    function automatic logic modeEff();
`ifdef TRDB_D5M_PIXEL_SOURCE_SNAPSHOT_EN
        return vif.ul1SnapshotMode;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic trigEff();
`ifdef TRDB_D5M_PIXEL_SOURCE_SNAPSHOT_EN
        return vif.ul1SnapshotTrigger;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRun   <= 1'b0;
            p      <= 0;
            mPat   <= 2'b00;
            mSnap  <= 1'b0;
            mCount <= 16'd0;
        end else if (!mRun) begin
            if (mLoad) mCount <= 16'hFFFF;
            if (vif.ul1Enable && (!modeEff() || trigEff())) begin
                mRun  <= 1'b1;
                p     <= 0;
                mPat  <= vif.ul2Pattern;
                mSnap <= modeEff();
            end
        end else if (p == L + V - 1) begin
            if (vif.ul1Enable && !modeEff()) begin
                p     <= 0;
                mPat  <= vif.ul2Pattern;
                mSnap <= 1'b0;
            end else begin
                mRun <= 1'b0;
            end
        end else begin
            p <= p + 1;
            if (p + 1 == L) mCount <= mCount + 16'd1;
        end
    end

    typedef struct packed {
        logic        fv;
        logic        lv;
        logic [11:0] d;
        logic        done;
        logic        strobe;
    } exp_t;

    function automatic logic [11:0] pix(input logic [1:0] pat, input int off, input int ln,
                                        input logic [15:0] cnt);
        case (pat)
            2'b00:   return 12'(off % 4096);
            2'b01:   return 12'(ln % 4096);
            2'b10:   return 12'((off + ln) % 4096);
            default: return cnt[11:0];
        endcase
    endfunction

    function automatic exp_t modelOut();
        exp_t e;
        int q, ln, off;
        e = '0;
        if (mRun && p < L) begin
            e.fv = 1'b1;
            if (p >= H) begin
                q   = p - H;
                ln  = q / (C + H);
                off = q % (C + H);
                if (off < C) begin
                    e.lv = 1'b1;
                    e.d  = pix(mPat, off, ln, mCount);
                end
            end
        end
        e.done   = mRun && (p == L);
        e.strobe = mRun && mSnap && (p < H);
        return e;
    endfunction

    task automatic compareAll(input exp_t e);
        check("cyc_fv",     int'(vif.ul1FrameValid),     int'(e.fv));
        check("cyc_lv",     int'(vif.ul1LineValid),      int'(e.lv));
        check("cyc_data",   int'(vif.ul12PixelData),     int'(e.d));
        check("cyc_done",   int'(vif.ul1FrameDone),      int'(e.done));
        check("cyc_strobe", int'(vif.ul1SnapshotStrobe), int'(e.strobe));
        check("cyc_count",  int'(vif.u16FrameCount),     int'(mCount));
    endtask

    always @(negedge clk) compareAll(modelOut());

    logic [11:0] lvQ[$];
    int P00[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int P10[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
    int P01[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int P11[12] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};

    task automatic checkSeq(input string name, input int exp[12]);
        check({name, "_len"}, lvQ.size(), 12);
        for (int i = 0; i < 12; i++)
            if (i < lvQ.size()) check($sformatf("%s[%0d]", name, i), int'(lvQ[i]), exp[i]);
    endtask

    // Captures one frame starting at its first FrameValid sample; applies mid-frame input changes at index midIdx.
    task automatic grabFrame(input int midIdx, input logic [1:0] midPat, input logic midEn,
                             input logic midTrig, input int lowBound,
                             output int fvLen, output int lowLen, output int doneCnt,
                             output int strobeCnt);
        int w;
        w = 0;
        fvLen = 0; lowLen = 0; doneCnt = 0; strobeCnt = 0;
        lvQ.delete();
        while (!vif.ul1FrameValid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("frame_start_timeout", 0, 1);
        while (vif.ul1FrameValid && fvLen < 100) begin
            if (vif.ul1LineValid) lvQ.push_back(vif.ul12PixelData);
            if (vif.ul1SnapshotStrobe) strobeCnt++;
            if (vif.ul1FrameDone) doneCnt++;
            if (fvLen == midIdx) begin
                vif.ul2Pattern         = midPat;
                vif.ul1Enable          = midEn;
                vif.ul1SnapshotTrigger = midTrig;
            end else begin
                vif.ul1SnapshotTrigger = 1'b0;
            end
            fvLen++;
            @(negedge clk);
        end
        vif.ul1SnapshotTrigger = 1'b0;
        while (!vif.ul1FrameValid && lowLen < lowBound) begin
            if (vif.ul1FrameDone) doneCnt++;
            lowLen++;
            @(negedge clk);
        end
    endtask

    int fvLen, lowLen, doneCnt, strobeCnt;

    initial begin
        vif.ul1Enable          = 1'b0;
        vif.ul1SnapshotMode    = 1'b0;
        vif.ul1SnapshotTrigger = 1'b0;
        vif.ul2Pattern         = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fv",    int'(vif.ul1FrameValid), 0);
        check("rst_lv",    int'(vif.ul1LineValid), 0);
        check("rst_data",  int'(vif.ul12PixelData), 0);
        check("rst_count", int'(vif.u16FrameCount), 0);
        check("rst_done",  int'(vif.ul1FrameDone), 0);
        rst = 1'b0;
        @(negedge clk);
        vif.ul1Enable = 1'b1;
        @(negedge clk);
        check("fv_rise", int'(vif.ul1FrameValid), 1);

        // Frame 1 pattern 00; pattern switched to 10 mid-frame must wait for frame 2.
        grabFrame(10, 2'b10, 1'b1, 1'b0, 40, fvLen, lowLen, doneCnt, strobeCnt);
        check("f1_fvlen", fvLen, 18);
        check("f1_vblank", lowLen, 5);
        check("f1_period", fvLen + lowLen, 23);
        check("f1_done", doneCnt, 1);
        check("f1_count", int'(vif.u16FrameCount), 1);
        checkSeq("f1_p00", P00);

        grabFrame(10, 2'b01, 1'b1, 1'b0, 40, fvLen, lowLen, doneCnt, strobeCnt);
        check("f2_fvlen", fvLen, 18);
        check("f2_count", int'(vif.u16FrameCount), 2);
        checkSeq("f2_p10", P10);

        grabFrame(10, 2'b11, 1'b1, 1'b0, 40, fvLen, lowLen, doneCnt, strobeCnt);
        checkSeq("f3_p01", P01);

        // Enable dropped in row 1: frame completes, then idle.
        grabFrame(10, 2'b00, 1'b0, 1'b0, 30, fvLen, lowLen, doneCnt, strobeCnt);
        check("f4_fvlen", fvLen, 18);
        check("f4_done", doneCnt, 1);
        check("f4_idle", lowLen, 30);
        check("f4_count", int'(vif.u16FrameCount), 4);
        checkSeq("f4_p11", P11);

        // Reset during row 1.
        vif.ul1Enable = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("prerst_lv", int'(vif.ul1LineValid), 1);
        check("prerst_data", int'(vif.ul12PixelData), 2);
        #2 rst = 1'b1;
        #1;
        check("midrst_fv",    int'(vif.ul1FrameValid), 0);
        check("midrst_lv",    int'(vif.ul1LineValid), 0);
        check("midrst_data",  int'(vif.ul12PixelData), 0);
        check("midrst_count", int'(vif.u16FrameCount), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_fv", int'(vif.ul1FrameValid), 1);
        grabFrame(-1, 2'b00, 1'b1, 1'b0, 40, fvLen, lowLen, doneCnt, strobeCnt);
        check("postrst_fvlen", fvLen, 18);
        check("postrst_count", int'(vif.u16FrameCount), 1);
        checkSeq("postrst_p00", P00);
        grabFrame(5, 2'b00, 1'b0, 1'b0, 30, fvLen, lowLen, doneCnt, strobeCnt);
        check("stop_idle", lowLen, 30);

        // Counter wrap: preload 65535 while idle.
        mLoad = 1'b1;
        @(posedge clk);
        #1 force dut.frameCount = 16'hFFFF;
        @(negedge clk);
        mLoad = 1'b0;
        @(posedge clk);
        #1 release dut.frameCount;
        @(negedge clk);
        check("wrap_pre", int'(vif.u16FrameCount), 65535);
        vif.ul2Pattern = 2'b11;
        vif.ul1Enable  = 1'b1;
        @(negedge clk);
        grabFrame(0, 2'b11, 1'b0, 1'b0, 30, fvLen, lowLen, doneCnt, strobeCnt);
        check("wrap_done", doneCnt, 1);
        check("wrap_count", int'(vif.u16FrameCount), 0);
        check("wrap_p11_len", lvQ.size(), 12);
        if (lvQ.size() > 0) check("wrap_p11_data", int'(lvQ[0]), 4095);

`ifdef TRDB_D5M_PIXEL_SOURCE_SNAPSHOT_EN
        vif.ul2Pattern      = 2'b00;
        vif.ul1SnapshotMode = 1'b1;
        vif.ul1Enable       = 1'b1;
        repeat (5) @(negedge clk);
        check("snap_wait_fv", int'(vif.ul1FrameValid), 0);
        vif.ul1SnapshotTrigger = 1'b1;
        @(negedge clk);
        vif.ul1SnapshotTrigger = 1'b0;
        check("snap_fv_rise", int'(vif.ul1FrameValid), 1);
        grabFrame(8, 2'b00, 1'b1, 1'b1, 30, fvLen, lowLen, doneCnt, strobeCnt);
        check("snap_fvlen", fvLen, 18);
        check("snap_strobe", strobeCnt, 2);
        check("snap_done", doneCnt, 1);
        check("snap_single", lowLen, 30);
        vif.ul1Enable          = 1'b0;
        vif.ul1SnapshotTrigger = 1'b1;
        @(negedge clk);
        vif.ul1SnapshotTrigger = 1'b0;
        repeat (5) @(negedge clk);
        check("snap_noen_fv", int'(vif.ul1FrameValid), 0);
`else
        vif.ul2Pattern      = 2'b00;
        vif.ul1SnapshotMode = 1'b1;
        vif.ul1Enable       = 1'b1;
        @(negedge clk);
        check("nosnap_fv_rise", int'(vif.ul1FrameValid), 1);
        grabFrame(5, 2'b00, 1'b0, 1'b1, 30, fvLen, lowLen, doneCnt, strobeCnt);
        check("nosnap_fvlen", fvLen, 18);
        check("nosnap_strobe", strobeCnt, 0);
        checkSeq("nosnap_p00", P00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
